// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, register address width and the
// MEM/WB control-bundle bit layout used by decode, MEM and write-back.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 9;

  // Control-bundle bit positions
  localparam int unsigned CTRL_LOAD_UNS   = 4;
  localparam int unsigned CTRL_REG_WRITE  = 5;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_LSIZE_LO   = 7;
  localparam int unsigned CTRL_LSIZE_HI   = 8;

  // Load size encodings; 2'b11 is treated as a full word
  typedef enum logic [1:0] {
    LsizeWord    = 2'b00,
    LsizeHalf    = 2'b01,
    LsizeByte    = 2'b10,
    LsizeWordAlt = 2'b11
  } lsize_e;

endpackage

// File: rtl/load_extract.sv
// Sub-word load extraction: picks the byte or halfword lane addressed by the
// low address bits and zero- or sign-extends it to XLEN.
// Ports:
//   mem_data      in   XLEN  raw load word
//   offset        in   2     byte offset within the word (alu_result[1:0])
//   size          in   2     load size (lsize_e encoding)
//   load_unsigned in   1     1 = zero-extend, 0 = sign-extend
//   load_data     out  XLEN  extracted/extended value
module load_extract
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = pipe_pkg::XLEN
) (
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_ext;
  logic        half_ext;

  always_comb begin
    byte_lane = mem_data[7:0];
    unique case (offset)
      2'd0: byte_lane = mem_data[7:0];
      2'd1: byte_lane = mem_data[15:8];
      2'd2: byte_lane = mem_data[23:16];
      2'd3: byte_lane = mem_data[31:24];
      default: byte_lane = mem_data[7:0];
    endcase
  end

  // Halfword lane only looks at offset[1]; misaligned halves are not split
  assign half_lane = offset[1] ? mem_data[31:16] : mem_data[15:0];

  assign byte_ext = ~load_unsigned & byte_lane[7];
  assign half_ext = ~load_unsigned & half_lane[15];

  always_comb begin
    load_data = mem_data;
    unique case (lsize_e'(size))
      LsizeHalf: load_data = {{(XLEN-16){half_ext}}, half_lane};
      LsizeByte: load_data = {{(XLEN-8){byte_ext}}, byte_lane};
      default:   load_data = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file.
// Selects ALU result or extracted load data, commits it to the register file,
// serves two combinational read ports with same-cycle write bypass, and
// counts committed writes.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   mem_data, alu_result MEM/WB load word and ALU result / address
//   ctrl_sig             MEM/WB control bundle
//   write_en, rd         register write enable and destination
//   rs1_addr, rs2_addr   ID read addresses
//   rs1_data, rs2_data   ID read data (bypassed, zero-latency)
//   wb_data, wb_valid    write-back value and forwarding qualifier
//   wb_rd                destination passthrough for forwarding compare
//   commit_count         committed writes since reset (wraps)
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = pipe_pkg::XLEN,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [8:0]       ctrl_sig,
  input  logic             write_en,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [CNT_W-1:0] commit_count
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  load_data;
  logic             mem_to_reg;
  logic             unused_ctrl;

  assign mem_to_reg = ctrl_sig[CTRL_MEM_TO_REG];
  // The write enable arrives on its own port; the copy in the bundle and the
  // bits consumed by other stages are not needed here.
  assign unused_ctrl = ^{ctrl_sig[3:0], ctrl_sig[CTRL_REG_WRITE]};

  load_extract #(
    .XLEN(XLEN)
  ) u_load_extract (
    .mem_data     (mem_data),
    .offset       (alu_result[1:0]),
    .size         (ctrl_sig[CTRL_LSIZE_HI:CTRL_LSIZE_LO]),
    .load_unsigned(ctrl_sig[CTRL_LOAD_UNS]),
    .load_data    (load_data)
  );

  assign wb_data      = mem_to_reg ? load_data : alu_result;
  assign wb_valid     = write_en && (rd != '0);
  assign wb_rd        = rd;
  assign commit_count = count_q;

  // x0 is forced to zero explicitly so reads are clean even before first reset;
  // wb_valid already excludes rd==0 from the bypass.
  always_comb begin
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wb_valid && (rs1_addr == rd)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wb_valid && (rs2_addr == rd)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // Reset takes priority and drops any write presented on the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else if (wb_valid) begin
      regs_q[rd] <= wb_data;
      count_q    <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
